// File: rtl/rvc_packer.sv
// RV32I -> RVC image compressor: re-encodes eligible instructions as 16-bit RVC
// and packs the stream little-endian into 32-bit instruction-memory words.
module rvc_packer #(
    parameter bit          EN_C  = 1'b1,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_word,
    output logic             out_last,
    output logic [CNT_W-1:0] cnt_in,
    output logic [CNT_W-1:0] cnt_comp
);

    localparam logic [6:0]  OP_IMM   = 7'b0010011;
    localparam logic [6:0]  OP_REG   = 7'b0110011;
    localparam logic [6:0]  OP_LOAD  = 7'b0000011;
    localparam logic [6:0]  OP_STORE = 7'b0100011;
    localparam logic [15:0] C_NOP    = 16'h0001;

    typedef enum logic [0:0] {RUN = 1'b0, PAD = 1'b1} state_t;

    state_t state_q, state_d;

    logic [15:0]      hold_q, hold_d;
    logic             hold_v_q, hold_v_nxt;
    logic             out_valid_q;
    logic [31:0]      out_word_q, word_d;
    logic             out_last_q, last_d;
    logic             load;
    logic [CNT_W-1:0] cnt_in_q, cnt_comp_q;

    logic             out_free;
    logic             accept;
    logic             comp_ok;
    logic [15:0]      comp_c;

    // Instruction field decode
    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [11:0] imm_i, imm_s;
    logic        is_32, imm_small, rd_p, rs1_p, rs2_p;
    logic        lw_off_ok, lwsp_off_ok, sw_off_ok, swsp_off_ok;

    assign opcode  = in_inst[6:0];
    assign rd      = in_inst[11:7];
    assign funct3  = in_inst[14:12];
    assign rs1     = in_inst[19:15];
    assign rs2     = in_inst[24:20];
    assign funct7  = in_inst[31:25];
    assign imm_i   = in_inst[31:20];
    assign imm_s   = {in_inst[31:25], in_inst[11:7]};
    assign is_32   = (in_inst[1:0] == 2'b11);

    // Immediate fits in 6-bit signed when bits [11:5] are pure sign extension
    assign imm_small   = (imm_i[11:5] == 7'h00) || (imm_i[11:5] == 7'h7f);
    assign rd_p        = (rd[4:3]  == 2'b01);
    assign rs1_p       = (rs1[4:3] == 2'b01);
    assign rs2_p       = (rs2[4:3] == 2'b01);
    assign lw_off_ok   = (imm_i[11:7] == 5'd0) && (imm_i[1:0] == 2'b00);
    assign lwsp_off_ok = (imm_i[11:8] == 4'd0) && (imm_i[1:0] == 2'b00);
    assign sw_off_ok   = (imm_s[11:7] == 5'd0) && (imm_s[1:0] == 2'b00);
    assign swsp_off_ok = (imm_s[11:8] == 4'd0) && (imm_s[1:0] == 2'b00);

    // Compression rules, first match wins
    always_comb begin : compress
        comp_ok = 1'b0;
        comp_c  = 16'h0000;
        if (EN_C && is_32) begin
            if (opcode == OP_IMM && funct3 == 3'b000 && rd != 5'd0 && rs1 == 5'd0
                && imm_small) begin
                comp_ok = 1'b1;
                comp_c  = {3'b010, imm_i[5], rd, imm_i[4:0], 2'b01};
            end else if (opcode == OP_IMM && funct3 == 3'b000 && rd != 5'd0 && rd == rs1
                         && imm_i != 12'd0 && imm_small) begin
                comp_ok = 1'b1;
                comp_c  = {3'b000, imm_i[5], rd, imm_i[4:0], 2'b01};
            end else if (opcode == OP_REG && funct3 == 3'b000 && funct7 == 7'd0
                         && rd != 5'd0 && rs1 == 5'd0 && rs2 != 5'd0) begin
                comp_ok = 1'b1;
                comp_c  = {4'b1000, rd, rs2, 2'b10};
            end else if (opcode == OP_REG && funct3 == 3'b000 && funct7 == 7'd0
                         && rd != 5'd0 && rd == rs1 && rs2 != 5'd0) begin
                comp_ok = 1'b1;
                comp_c  = {4'b1001, rd, rs2, 2'b10};
            end else if (opcode == OP_LOAD && funct3 == 3'b010 && rd_p && rs1_p
                         && lw_off_ok) begin
                comp_ok = 1'b1;
                comp_c  = {3'b010, imm_i[5:3], rs1[2:0], imm_i[2], imm_i[6], rd[2:0], 2'b00};
            end else if (opcode == OP_STORE && funct3 == 3'b010 && rs1_p && rs2_p
                         && sw_off_ok) begin
                comp_ok = 1'b1;
                comp_c  = {3'b110, imm_s[5:3], rs1[2:0], imm_s[2], imm_s[6], rs2[2:0], 2'b00};
            end else if (opcode == OP_LOAD && funct3 == 3'b010 && rs1 == 5'd2
                         && rd != 5'd0 && lwsp_off_ok) begin
                comp_ok = 1'b1;
                comp_c  = {3'b010, imm_i[5], rd, imm_i[4:2], imm_i[7:6], 2'b10};
            end else if (opcode == OP_STORE && funct3 == 3'b010 && rs1 == 5'd2
                         && swsp_off_ok) begin
                comp_ok = 1'b1;
                comp_c  = {3'b110, imm_s[5:2], imm_s[7:6], rs2, 2'b10};
            end
        end
    end

    assign out_free = !out_valid_q || out_ready;
    assign in_ready = (state_q == RUN) && out_free;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin : state_reg
        if (!rst_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin : fsm_next
        state_d = state_q;
        case (state_q)
            RUN: if (accept && in_last && hold_v_nxt) state_d = PAD;
            PAD: if (out_free) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // Packing decisions and output-word formation
    always_comb begin : fsm_out
        load       = 1'b0;
        word_d     = out_word_q;
        last_d     = 1'b0;
        hold_d     = hold_q;
        hold_v_nxt = hold_v_q;
        case (state_q)
            RUN: begin
                if (accept) begin
                    if (!hold_v_q) begin
                        if (comp_ok) begin
                            hold_d     = comp_c;
                            hold_v_nxt = 1'b1;
                        end else begin
                            load   = 1'b1;
                            word_d = in_inst;
                        end
                    end else begin
                        load = 1'b1;
                        if (comp_ok) begin
                            word_d     = {comp_c, hold_q};
                            hold_v_nxt = 1'b0;
                        end else begin
                            word_d = {in_inst[15:0], hold_q};
                            hold_d = in_inst[31:16];
                        end
                    end
                    last_d = in_last && !hold_v_nxt;
                end
            end
            PAD: begin
                if (out_free) begin
                    load       = 1'b1;
                    word_d     = {C_NOP, hold_q};
                    last_d     = 1'b1;
                    hold_v_nxt = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin : hold_reg
        if (!rst_n) begin
            hold_q   <= 16'h0000;
            hold_v_q <= 1'b0;
        end else begin
            hold_q   <= hold_d;
            hold_v_q <= hold_v_nxt;
        end
    end

    // Output word register; a load only happens when the slot is free
    always_ff @(posedge clk) begin : out_reg
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_word_q  <= 32'h0000_0000;
            out_last_q  <= 1'b0;
        end else if (load) begin
            out_valid_q <= 1'b1;
            out_word_q  <= word_d;
            out_last_q  <= last_d;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin : stat_cnt
        if (!rst_n) begin
            cnt_in_q   <= '0;
            cnt_comp_q <= '0;
        end else begin
            if (accept && cnt_in_q != '1) begin
                cnt_in_q <= cnt_in_q + CNT_W'(1);
            end
            if (accept && comp_ok && cnt_comp_q != '1) begin
                cnt_comp_q <= cnt_comp_q + CNT_W'(1);
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_word  = out_word_q;
    assign out_last  = out_last_q;
    assign cnt_in    = cnt_in_q;
    assign cnt_comp  = cnt_comp_q;

endmodule

// File: tb/tb_rvc_packer.sv
// Scoreboard bench for rvc_packer: a compressing instance and a pass-through
// instance with narrow counters share one beat driver.
module tb_rvc_packer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vld = 1'b0;
    logic        sel_nc = 1'b0;
    logic [31:0] in_inst = 32'h0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b1;

    logic        in_valid_m, in_ready_m, out_valid_m, out_last_m;
    logic [31:0] out_word_m;
    logic [15:0] cnt_in_m, cnt_comp_m;
    logic        in_valid_n, in_ready_n, out_valid_n, out_last_n;
    logic [31:0] out_word_n;
    logic [2:0]  cnt_in_n, cnt_comp_n;

    int n_cmp = 0;
    int n_fail = 0;

    logic [32:0] exp_q[$];
    logic [32:0] obs_m[$];
    logic [32:0] obs_n[$];

    assign in_valid_m = vld && !sel_nc;
    assign in_valid_n = vld && sel_nc;

    always #5 clk = ~clk;

    rvc_packer #(.EN_C(1'b1), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_m), .in_ready(in_ready_m), .in_inst(in_inst), .in_last(in_last),
        .out_valid(out_valid_m), .out_ready(out_ready), .out_word(out_word_m),
        .out_last(out_last_m), .cnt_in(cnt_in_m), .cnt_comp(cnt_comp_m)
    );

    rvc_packer #(.EN_C(1'b0), .CNT_W(3)) dut_nc (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_n), .in_ready(in_ready_n), .in_inst(in_inst), .in_last(in_last),
        .out_valid(out_valid_n), .out_ready(out_ready), .out_word(out_word_n),
        .out_last(out_last_n), .cnt_in(cnt_in_n), .cnt_comp(cnt_comp_n)
    );

    // Record every word transfer; inputs change only just after posedge
    always @(negedge clk) begin
        if (rst_n && out_valid_m && out_ready) obs_m.push_back({out_last_m, out_word_m});
        if (rst_n && out_valid_n && out_ready) obs_n.push_back({out_last_n, out_word_n});
    end

    task automatic apply_reset();
        rst_n = 1'b0;
        vld = 1'b0;
        sel_nc = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        exp_q.delete();
        obs_m.delete();
        obs_n.delete();
    endtask

    task automatic send_beat(input logic [31:0] inst, input logic last);
        bit done;
        done = 1'b0;
        vld = 1'b1;
        in_inst = inst;
        in_last = last;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (sel_nc ? in_ready_n : in_ready_m) done = 1'b1;
            @(posedge clk);
            #1;
        end
        vld = 1'b0;
        in_last = 1'b0;
        if (!done) begin
            n_cmp++;
            n_fail++;
            $display("FAIL beat_accept: inst %h not accepted within 50 cycles", inst);
        end
    endtask

    task automatic wait_words(input bit nc);
        for (int t = 0; t < 60 && (nc ? obs_n.size() : obs_m.size()) < exp_q.size(); t++)
            @(negedge clk);
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        n_cmp++; if (out_valid_m !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", out_valid_m); end
        n_cmp++; if (in_ready_m !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b want 1", in_ready_m); end
        n_cmp++; if (out_word_m !== 32'h0) begin n_fail++; $display("FAIL rst_out_word: got %h want 0", out_word_m); end
        n_cmp++; if (out_last_m !== 1'b0) begin n_fail++; $display("FAIL rst_out_last: got %b want 0", out_last_m); end
        n_cmp++; if (cnt_in_m !== 16'd0 || cnt_comp_m !== 16'd0) begin
            n_fail++; $display("FAIL rst_counters: got in=%0d comp=%0d want 0/0", cnt_in_m, cnt_comp_m);
        end
    endtask

    task automatic test_pad_single();
        logic [32:0] e, g;
        apply_reset();
        exp_q.push_back({1'b1, 32'h0001_0515});
        send_beat(32'h0055_0513, 1'b1);
        wait_words(1'b0);
        n_cmp++; if (obs_m.size() != exp_q.size()) begin n_fail++; $display("FAIL pad_count: got %0d want %0d", obs_m.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_m.size() > 0) begin
            e = exp_q.pop_front(); g = obs_m.pop_front();
            n_cmp++; if (g !== e) begin n_fail++; $display("FAIL pad_word: got %h want %h", g, e); end
        end
        n_cmp++; if (cnt_comp_m !== 16'd1 || cnt_in_m !== 16'd1) begin
            n_fail++; $display("FAIL pad_counters: got in=%0d comp=%0d want 1/1", cnt_in_m, cnt_comp_m);
        end
    endtask

    task automatic test_back_to_back();
        logic [32:0] e, g;
        apply_reset();
        exp_q.push_back({1'b0, 32'h0513_0515});
        exp_q.push_back({1'b1, 32'h952E_0645});
        send_beat(32'h0055_0513, 1'b0);
        send_beat(32'h0645_0513, 1'b0);
        send_beat(32'h00B5_0533, 1'b1);
        wait_words(1'b0);
        n_cmp++; if (obs_m.size() != exp_q.size()) begin n_fail++; $display("FAIL b2b_count: got %0d want %0d", obs_m.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_m.size() > 0) begin
            e = exp_q.pop_front(); g = obs_m.pop_front();
            n_cmp++; if (g !== e) begin n_fail++; $display("FAIL b2b_word: got %h want %h", g, e); end
        end
    endtask

    task automatic test_load_li();
        logic [32:0] e, g;
        apply_reset();
        exp_q.push_back({1'b1, 32'h52FD_4404});
        send_beat(32'h0084_2483, 1'b0);
        send_beat(32'hFFF0_0293, 1'b1);
        wait_words(1'b0);
        n_cmp++; if (obs_m.size() != exp_q.size()) begin n_fail++; $display("FAIL lwli_count: got %0d want %0d", obs_m.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_m.size() > 0) begin
            e = exp_q.pop_front(); g = obs_m.pop_front();
            n_cmp++; if (g !== e) begin n_fail++; $display("FAIL lwli_word: got %h want %h", g, e); end
        end
        n_cmp++; if (cnt_comp_m !== 16'd2) begin n_fail++; $display("FAIL lwli_cnt_comp: got %0d want 2", cnt_comp_m); end
    endtask

    // Remaining rules plus immediate/offset boundaries and branch pass-through
    task automatic test_rules();
        logic [32:0] e, g;
        apply_reset();
        exp_q.push_back({1'b0, 32'hC044_829A});
        exp_q.push_back({1'b0, 32'hDF86_40B2});
        exp_q.push_back({1'b0, 32'h0205_0513});
        exp_q.push_back({1'b0, 32'h0463_5281});
        exp_q.push_back({1'b1, 32'h057D_00B5});
        send_beat(32'h0060_02B3, 1'b0);  // add x5,x0,x6   -> c.mv
        send_beat(32'h0094_2223, 1'b0);  // sw x9,4(x8)    -> c.sw
        send_beat(32'h00C1_2083, 1'b0);  // lw x1,12(x2)   -> c.lwsp
        send_beat(32'h0E11_2E23, 1'b0);  // sw x1,252(x2)  -> c.swsp
        send_beat(32'h0205_0513, 1'b0);  // addi imm=32 stays 32-bit
        send_beat(32'hFE00_0293, 1'b0);  // li x5,-32
        send_beat(32'h00B5_0463, 1'b0);  // beq stays 32-bit
        send_beat(32'h01F5_0513, 1'b1);  // addi x10,x10,31
        wait_words(1'b0);
        n_cmp++; if (obs_m.size() != exp_q.size()) begin n_fail++; $display("FAIL rules_count: got %0d want %0d", obs_m.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_m.size() > 0) begin
            e = exp_q.pop_front(); g = obs_m.pop_front();
            n_cmp++; if (g !== e) begin n_fail++; $display("FAIL rules_word: got %h want %h", g, e); end
        end
        n_cmp++; if (cnt_in_m !== 16'd8 || cnt_comp_m !== 16'd6) begin
            n_fail++; $display("FAIL rules_counters: got in=%0d comp=%0d want 8/6", cnt_in_m, cnt_comp_m);
        end
    endtask

    task automatic test_disable();
        logic [32:0] e, g;
        apply_reset();
        sel_nc = 1'b1;
        exp_q.push_back({1'b0, 32'h0055_0513});
        exp_q.push_back({1'b1, 32'h00B5_0533});
        send_beat(32'h0055_0513, 1'b0);
        send_beat(32'h00B5_0533, 1'b1);
        wait_words(1'b1);
        n_cmp++; if (obs_n.size() != exp_q.size()) begin n_fail++; $display("FAIL nc_count: got %0d want %0d", obs_n.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_n.size() > 0) begin
            e = exp_q.pop_front(); g = obs_n.pop_front();
            n_cmp++; if (g !== e) begin n_fail++; $display("FAIL nc_word: got %h want %h", g, e); end
        end
        n_cmp++; if (cnt_comp_n !== 3'd0 || cnt_in_n !== 3'd2) begin
            n_fail++; $display("FAIL nc_counters: got in=%0d comp=%0d want 2/0", cnt_in_n, cnt_comp_n);
        end
        sel_nc = 1'b0;
    endtask

    task automatic test_saturate();
        logic [32:0] e, g;
        apply_reset();
        sel_nc = 1'b1;
        for (int i = 0; i < 9; i++) begin
            exp_q.push_back({(i == 8), 32'h0000_0013});
            send_beat(32'h0000_0013, (i == 8));
            if (i == 5) begin
                n_cmp++; if (cnt_in_n !== 3'd6) begin n_fail++; $display("FAIL sat_mid: got %0d want 6", cnt_in_n); end
            end
        end
        wait_words(1'b1);
        n_cmp++; if (cnt_in_n !== 3'd7) begin n_fail++; $display("FAIL sat_hold: got %0d want 7", cnt_in_n); end
        n_cmp++; if (obs_n.size() != exp_q.size()) begin n_fail++; $display("FAIL sat_count: got %0d want %0d", obs_n.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_n.size() > 0) begin
            e = exp_q.pop_front(); g = obs_n.pop_front();
            n_cmp++; if (g !== e) begin n_fail++; $display("FAIL sat_word: got %h want %h", g, e); end
        end
        sel_nc = 1'b0;
    endtask

    task automatic test_stall();
        logic [32:0] e, g;
        apply_reset();
        out_ready = 1'b0;
        exp_q.push_back({1'b0, 32'h0645_0513});
        exp_q.push_back({1'b0, 32'h0513_952E});
        exp_q.push_back({1'b1, 32'h0515_0645});
        fork
            begin
                send_beat(32'h0645_0513, 1'b0);
                send_beat(32'h00B5_0533, 1'b0);
                send_beat(32'h0645_0513, 1'b0);
                send_beat(32'h0055_0513, 1'b1);
            end
            begin
                for (int t = 0; t < 50 && !out_valid_m; t++) @(negedge clk);
                for (int c = 0; c < 5; c++) begin
                    n_cmp++; if (out_word_m !== 32'h0645_0513 || in_ready_m !== 1'b0) begin
                        n_fail++; $display("FAIL stall_hold: got word=%h in_ready=%b want word=06450513 in_ready=0", out_word_m, in_ready_m);
                    end
                    @(negedge clk);
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        wait_words(1'b0);
        n_cmp++; if (obs_m.size() != exp_q.size()) begin n_fail++; $display("FAIL stall_count: got %0d want %0d", obs_m.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_m.size() > 0) begin
            e = exp_q.pop_front(); g = obs_m.pop_front();
            n_cmp++; if (g !== e) begin n_fail++; $display("FAIL stall_word: got %h want %h", g, e); end
        end
        n_cmp++; if (cnt_in_m !== 16'd4 || cnt_comp_m !== 16'd2) begin
            n_fail++; $display("FAIL stall_counters: got in=%0d comp=%0d want 4/2", cnt_in_m, cnt_comp_m);
        end
    endtask

    task automatic test_reset_in_pad();
        apply_reset();
        out_ready = 1'b0;
        send_beat(32'h0055_0513, 1'b0);
        send_beat(32'h0645_0513, 1'b1);
        @(negedge clk);
        n_cmp++; if (in_ready_m !== 1'b0 || out_valid_m !== 1'b1) begin
            n_fail++; $display("FAIL pad_wait: got in_ready=%b out_valid=%b want 0/1", in_ready_m, out_valid_m);
        end
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_cmp++; if (out_valid_m !== 1'b0) begin n_fail++; $display("FAIL rstpad_valid: got %b want 0", out_valid_m); end
        n_cmp++; if (cnt_in_m !== 16'd0 || cnt_comp_m !== 16'd0) begin
            n_fail++; $display("FAIL rstpad_counters: got in=%0d comp=%0d want 0/0", cnt_in_m, cnt_comp_m);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (10) @(negedge clk);
        n_cmp++; if (obs_m.size() != 0) begin n_fail++; $display("FAIL rstpad_no_word: got %0d words want 0", obs_m.size()); end
        n_cmp++; if (in_ready_m !== 1'b1) begin n_fail++; $display("FAIL rstpad_ready: got %b want 1", in_ready_m); end
    endtask

    initial begin
        test_reset();
        test_pad_single();
        test_back_to_back();
        test_load_li();
        test_rules();
        test_disable();
        test_saturate();
        test_stall();
        test_reset_in_pad();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/rvc_packer.md
# rvc_packer

Instruction-image compressor: the encoder counterpart of the fetch-side RVC expander. It accepts a stream of 32-bit RV32I instructions and re-encodes eligible ones as 16-bit RVC. It packs the result little-endian into 32-bit words for instruction memory: lower halfword is the lower address, so pc bit 1 = 0 selects bits [15:0]. It sits between the image generator/loader and the instruction-memory write port.

## Interface
- `EN_C`, 1: 0 disables compression; every instruction passes through as 32-bit.
- `CNT_W`, 16: width of the statistics counters.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `in_valid` in 1: input beat valid.
- `in_ready` out 1: input beat accepted when `in_valid && in_ready`.
- `in_inst` in 32: RV32I instruction.
- `in_last` in 1: marks the final instruction of the image.
- `out_valid` out 1: packed word valid.
- `out_ready` in 1: downstream accepts the word when `out_valid && out_ready`.
- `out_word` out 32: packed instruction word.
- `out_last` out 1: final word of the image.
- `cnt_in` out CNT_W: instructions accepted; saturating.
- `cnt_comp` out CNT_W: instructions compressed; saturating.

## Operation
- Compression rules are checked in this order. Each applies only when `EN_C`=1, opcode/funct match exactly and the instruction is 32-bit (bits[1:0]=11).
  - `addi` rd≠0, rs1=x0, imm∈[-32,31] → C.LI {010,imm[5],rd,imm[4:0],01}.
  - `addi` rd=rs1≠0, imm≠0, imm∈[-32,31] → C.ADDI {000,imm[5],rd,imm[4:0],01}.
  - `add` (funct7=0) rd≠0, rs1=x0, rs2≠0 → C.MV {1000,rd,rs2,10}.
  - `add` rd=rs1≠0, rs2≠0 → C.ADD {1001,rd,rs2,10}.
  - `lw` rd,rs1∈x8..x15, off∈[0,124], off%4=0 → C.LW {010,off[5:3],rs1',off[2],off[6],rd',00}.
  - `sw` rs1,rs2∈x8..x15, same offset rule → C.SW {110,off[5:3],rs1',off[2],off[6],rs2',00}.
  - `lw` rs1=x2, rd≠0, off∈[0,252], off%4=0 → C.LWSP {010,off[5],rd,off[4:2],off[7:6],10}.
  - `sw` rs1=x2, off∈[0,252], off%4=0 → C.SWSP {110,off[5:2],off[7:6],rs2,10}.
  - Anything else, including all branches and jumps, passes unchanged. The image generator owns offset layout and applies identical rules.
- Packing uses a 16-bit `hold` register plus `hold_v`. On each accepted beat:
  - hold empty, compressible: hold←c, hold_v←1, no output.
  - hold empty, 32-bit: out_word←inst.
  - hold full, compressible: out_word←{c,hold}, hold_v←0.
  - hold full, 32-bit: out_word←{inst[15:0],hold}, hold←inst[31:16], hold_v stays 1.
- FSM has states RUN and PAD.
  - RUN: accepted beat with `in_last`=1 and resulting hold_v=1 → PAD. The word produced by that beat, if any, has out_last=0.
  - RUN: accepted beat with `in_last`=1 and resulting hold_v=0 → the word produced has out_last=1; stay in RUN.
  - PAD: emits {16'h0001 (C.NOP), hold} with out_last=1 once the output register is free, then clears hold_v and returns to RUN.
- `in_ready` = (state==RUN) && (!out_valid || out_ready). The same rule applies to beats that produce no output.
- Counters: `cnt_in` +1 per accepted beat; `cnt_comp` +1 per compressed beat; both hold at all-ones.

## Timing
- Reset values: out_valid=0, out_word=0, out_last=0, hold_v=0, state=RUN, cnt_in=0, cnt_comp=0. `in_ready`=1 the cycle after reset deasserts.
- Latency: a word is registered on the cycle its completing beat is accepted; `out_valid` is high the following cycle.
- `out_word`/`out_last` are stable while `out_valid && !out_ready`.
- Full throughput, one beat per cycle, when out_ready=1. Output accepted and new word loaded in the same cycle is allowed.
- PAD occupies one cycle of output slot; `in_ready`=0 throughout PAD.
- Reset mid-operation discards hold, any pending word and PAD state; no partial word is emitted.

## Test plan
- Reset, then 0x00550513 (addi x10,x10,5) with in_last=1 → one word 0x00010515, out_last=1; cnt_comp=1.
- Beats 0x00550513, 0x06450513, 0x00B50533 (last) → 0x05130515, then 0x952E0645, out_last=1 on the second.
- 0x00842483 (lw x9,8(x8)) then 0xFFF00293 (li x5,-1, last) → 0x52FD4404, out_last=1; cnt_comp=2.
- EN_C=0, 0x00550513 then 0x00B50533 (last) → 0x00550513, then 0x00B50533 with out_last=1; cnt_comp=0.
- out_ready held 0 for 5 cycles with words pending → out_word constant, in_ready=0, no beat lost; release → words in order.
- Assert rst_n=0 while hold_v=1 in PAD → out_valid=0 next cycle, no pad word; counters return to 0.
